usb_cdc_tx_arbiter: RTL

//   Shares the single byte-wide TX FIFO write port of the USB CDC core between

---
 rtl/usb_cdc_tx_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/usb_cdc_tx_arbiter.sv
// Round-robin arbiter sharing the USB CDC TX FIFO write port between NREQ byte streams.
// Optional `USB_CDC_TXARB_PRIO_EN gives requester 0 fixed priority in IDLE.
module usb_cdc_tx_arbiter #(
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 8,
    localparam int GW       = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*8-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    input  logic              tx_fifo_full,
    output logic              tx_fifo_wr,
    output logic [7:0]        tx_fifo_wdata,
    output logic [GW-1:0]     grant_id,
    output logic              busy
);
    // Handshake: a byte moves when req_valid[g] & req_ready[g]; ready never depends on valid.
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;
`ifdef USB_CDC_TXARB_PRIO_EN
    localparam bit PRIO_EN = 1'b1;
`else
    localparam bit PRIO_EN = 1'b0;
`endif

    logic [0:0]    state_q, state_d;
    logic [GW-1:0] ptr_q, ptr_d;
    logic [GW-1:0] grant_id_q, grant_id_d;
    logic [BW-1:0] burst_cnt_q, burst_cnt_d;

    logic          sel_valid, sel_last;
    logic [7:0]    sel_data;
    logic          grant_ok, wr;
    logic          pick_found;
    logic [GW-1:0] pick_idx;
    logic [GW-1:0] ptr_after;
    logic          release_grant;

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_id_q == GW'(i)) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[i*8 +: 8];
            end
        end
    end

    // rst gates the strobe so a byte presented during the reset cycle is never written.
    assign busy     = (state_q == S_GRANT);
    assign grant_ok = busy & en & ~tx_fifo_full & ~rst;
    assign wr       = grant_ok & sel_valid;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = grant_ok && (grant_id_q == GW'(i));
        end
    end

    assign tx_fifo_wr    = wr;
    assign tx_fifo_wdata = busy ? sel_data : 8'h00;
    assign grant_id      = grant_id_q;

    // First valid requester scanning ptr, ptr+1, ... modulo NREQ.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pick_found && req_valid[i] && (i == (int'(ptr_q) + k) % NREQ)) begin
                    pick_found = 1'b1;
                    pick_idx   = GW'(i);
                end
            end
        end
        if (PRIO_EN && req_valid[0]) begin
            pick_found = 1'b1;
            pick_idx   = '0;
        end
    end

    assign ptr_after = (grant_id_q == GW'(NREQ - 1)) ? '0 : grant_id_q + GW'(1);

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grant_id_d    = grant_id_q;
        burst_cnt_d   = burst_cnt_q;
        release_grant = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (en && pick_found) begin
                    state_d     = S_GRANT;
                    grant_id_d  = pick_idx;
                    burst_cnt_d = '0;
                end
            end
            S_GRANT: begin
                if (wr) begin
                    burst_cnt_d = burst_cnt_q + BW'(1);
                    if (sel_last || (burst_cnt_q == BW'(MAX_BURST - 1))) begin
                        release_grant = 1'b1;
                    end
                end else if (grant_ok && !sel_valid) begin
                    release_grant = 1'b1;
                end
                if (release_grant) begin
                    state_d = S_IDLE;
                    if (!(PRIO_EN && (grant_id_q == '0))) begin
                        ptr_d = ptr_after;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            grant_id_q  <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_id_q  <= grant_id_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end
endmodule
